// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment bus receiver: field layout, widths
// and the active-low hex font.
package ssd_pkg;

  localparam int SSD_DIGITS  = 4;
  localparam int SSD_SEG_W   = 7;
  localparam int SSD_AN_W    = 4;
  localparam int SSD_BUS_W   = SSD_AN_W + SSD_SEG_W;

  localparam int SSD_AN_MSB  = 10;
  localparam int SSD_AN_LSB  = 7;
  localparam int SSD_SEG_MSB = 6;
  localparam int SSD_SEG_LSB = 0;

  // Segment order is g..a (bit6..bit0), low = lit
  localparam logic [SSD_SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SSD_SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SSD_SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SSD_SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SSD_SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SSD_SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SSD_SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SSD_SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SSD_SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SSD_SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SSD_SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SSD_SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SSD_SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SSD_SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SSD_SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SSD_SEG_W-1:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational hex-font decoder: active-low segments to a nibble, with a flag
// that is low for any pattern outside the 16-glyph font.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [SSD_SEG_W-1:0] seg,
  output logic [3:0]           nibble,
  output logic                 ok
);

  always_comb begin
    nibble = 4'h0;
    ok     = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: ok     = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_frame_decoder.sv
// Reconstructs the four hex digits shown on a multiplexed seven-segment bus.
// Define SSD_FRAME_DECODER_ERR_EN to accept undecodable glyphs as 0 and flag the frame.
module ssd_frame_decoder
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SSD_BUS_W-1:0] ssd_in,
  output logic [15:0]          value,
  output logic                 value_valid,
  output logic                 frame_strobe,
  output logic                 frame_error
);

  logic [SSD_BUS_W-1:0]  prev_q;
  logic [7:0]            cnt_q;
  logic [15:0]           slots_q;
  logic [SSD_DIGITS-1:0] seen_q;

  logic [SSD_AN_W-1:0]   an;
  logic [SSD_SEG_W-1:0]  seg;
  logic [3:0]            dec_nib;
  logic                  dec_ok;

  logic                  same;
  logic [8:0]            run_len;
  logic                  stable_hit;
  logic [SSD_DIGITS-1:0] slot_oh;
  logic                  an_ok;
  logic                  accept;
  logic                  err_hit;
  logic [3:0]            nib_acc;
  logic [15:0]           slots_n;
  logic [SSD_DIGITS-1:0] seen_n;
  logic                  frame_done;

  assign an  = ssd_in[SSD_AN_MSB:SSD_AN_LSB];
  assign seg = ssd_in[SSD_SEG_MSB:SSD_SEG_LSB];

  ssd_seg_decode u_dec (
    .seg    (seg),
    .nibble (dec_nib),
    .ok     (dec_ok)
  );

  // run_len is the number of identical consecutive samples including this one;
  // the counter holds that length minus two while the bus stays put.
  assign same       = (ssd_in == prev_q);
  assign run_len    = same ? ({1'b0, cnt_q} + 9'd2) : 9'd1;
  assign stable_hit = (run_len == 9'(STABLE_CYCLES));

  assign slot_oh = ~an;
  assign an_ok   = (slot_oh != '0) && ((slot_oh & (slot_oh - 1'b1)) == '0);

`ifdef SSD_FRAME_DECODER_ERR_EN
  assign accept  = stable_hit && an_ok;
  assign err_hit = !dec_ok;
  assign nib_acc = dec_ok ? dec_nib : 4'h0;
`else
  assign accept  = stable_hit && an_ok && dec_ok;
  assign err_hit = 1'b0;
  assign nib_acc = dec_nib;
`endif

  always_comb begin
    slots_n = slots_q;
    for (int k = 0; k < SSD_DIGITS; k++) begin
      if (slot_oh[k]) slots_n[4*k +: 4] = nib_acc;
    end
  end

  assign seen_n     = seen_q | slot_oh;
  assign frame_done = accept && (&seen_n);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q       <= '0;
      cnt_q        <= '0;
      slots_q      <= '0;
      seen_q       <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      prev_q       <= ssd_in;
      frame_strobe <= 1'b0;
      if (!same)
        cnt_q <= '0;
      else if (cnt_q < 8'(STABLE_CYCLES))
        cnt_q <= cnt_q + 8'd1;
      if (accept) begin
        slots_q <= slots_n;
        if (frame_done) begin
          seen_q       <= '0;
          value        <= slots_n;
          value_valid  <= 1'b1;
          frame_strobe <= 1'b1;
        end else begin
          seen_q <= seen_n;
        end
      end
    end
  end

`ifdef SSD_FRAME_DECODER_ERR_EN
  logic err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      frame_error <= 1'b0;
    end else if (accept) begin
      if (frame_done) begin
        frame_error <= err_q || err_hit;
        err_q       <= 1'b0;
      end else begin
        err_q <= err_q || err_hit;
      end
    end
  end
`else
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_frame_decoder.sv
// Bench for ssd_frame_decoder: directed scenarios plus random bus traffic,
// checked every cycle against a run-length/slot model for STABLE_CYCLES 4 and 1.
module tb_ssd_frame_decoder;

  localparam int NDUT = 2;
  localparam int SC [NDUT] = '{4, 1};
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    logic [10:0] last;
    int          run;
    logic [15:0] slots;
    logic [3:0]  seen;
    logic        err;
    logic [15:0] value;
    logic        valid;
    logic        strobe;
    logic        ferr;
  } model_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] ssd_in;
  logic [15:0] value        [NDUT];
  logic        value_valid  [NDUT];
  logic        frame_strobe [NDUT];
  logic        frame_error  [NDUT];

  model_t m [NDUT];
  int tests = 0;
  int fails = 0;
  int strobes [NDUT] = '{0, 0};

  always #5 clock = ~clock;

  ssd_frame_decoder #(.STABLE_CYCLES(4)) dut_s4 (
    .clock(clock), .reset(reset), .ssd_in(ssd_in),
    .value(value[0]), .value_valid(value_valid[0]),
    .frame_strobe(frame_strobe[0]), .frame_error(frame_error[0]));

  ssd_frame_decoder #(.STABLE_CYCLES(1)) dut_s1 (
    .clock(clock), .reset(reset), .ssd_in(ssd_in),
    .value(value[1]), .value_valid(value_valid[1]),
    .frame_strobe(frame_strobe[1]), .frame_error(frame_error[1]));

  function automatic model_t model_reset();
    model_t r;
    r.last = '0; r.run = 1; r.slots = '0; r.seen = '0; r.err = 1'b0;
    r.value = '0; r.valid = 1'b0; r.strobe = 1'b0; r.ferr = 1'b0;
    return r;
  endfunction

  // A digit is taken when exactly sc identical samples have been seen in a row.
  function automatic model_t model_step(model_t cur, logic [10:0] s, int sc);
    model_t r = cur;
    int zeros = 0;
    int k = 0;
    logic ok = 1'b0;
    logic take;
    logic [3:0] nib = 4'h0;
    r.strobe = 1'b0;
    if (s == cur.last) r.run = cur.run + 1;
    else begin r.run = 1; r.last = s; end
    if (r.run == sc) begin
      for (int b = 0; b < 4; b++) if (!s[7+b]) begin zeros++; k = b; end
      for (int d = 0; d < 16; d++) if (FONT[d] == s[6:0]) begin ok = 1'b1; nib = 4'(d); end
      if (zeros == 1) begin
`ifdef SSD_FRAME_DECODER_ERR_EN
        take = 1'b1;
        if (!ok) begin r.err = 1'b1; nib = 4'h0; end
`else
        take = ok;
`endif
        if (take) begin
          r.slots[4*k +: 4] = nib;
          r.seen[k] = 1'b1;
          if (r.seen == 4'hF) begin
            r.value  = r.slots;
            r.valid  = 1'b1;
            r.strobe = 1'b1;
`ifdef SSD_FRAME_DECODER_ERR_EN
            r.ferr   = r.err;
`endif
            r.seen   = '0;
            r.err    = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < NDUT; i++) begin
      if (reset) m[i] <= model_reset();
      else       m[i] <= model_step(m[i], ssd_in, SC[i]);
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < NDUT; i++) begin
      tests++;
      if ({value[i], value_valid[i], frame_strobe[i], frame_error[i]} !==
          {m[i].value, m[i].valid, m[i].strobe, m[i].ferr}) begin
        fails++;
        $display("FAIL model_cmp dut%0d t=%0t: got value=%h valid=%b strobe=%b err=%b, expected value=%h valid=%b strobe=%b err=%b",
                 i, $time, value[i], value_valid[i], frame_strobe[i], frame_error[i],
                 m[i].value, m[i].valid, m[i].strobe, m[i].ferr);
      end
      if (frame_strobe[i]) strobes[i]++;
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(logic [10:0] b, int n);
    ssd_in = b;
    repeat (n) @(negedge clock);
    #1;
  endtask

  int s0, s1;
  logic [3:0] an_r;
  logic [6:0] seg_r;

  initial begin
    reset  = 1'b1;
    ssd_in = 11'h7FF;
    repeat (2) @(negedge clock);
    #1;
    check("reset_value", 32'(value[0]), 32'h0);
    check("reset_valid", 32'(value_valid[0]), 32'h0);
    check("reset_strobe", 32'(frame_strobe[0]), 32'h0);
    check("reset_error", 32'(frame_error[0]), 32'h0);
    reset = 1'b0;

    // Basic frame 3210
    s0 = strobes[0];
    drive({4'b1110, 7'b1000000}, 4);
    drive({4'b1101, 7'b1111001}, 4);
    drive({4'b1011, 7'b0100100}, 4);
    drive({4'b0111, 7'b0110000}, 4);
    check("frame_3210_value", 32'(value[0]), 32'h3210);
    check("frame_3210_strobe", 32'(frame_strobe[0]), 32'h1);
    check("frame_3210_valid", 32'(value_valid[0]), 32'h1);
    check("frame_3210_count", 32'(strobes[0] - s0), 32'h1);
    check("frame_3210_s1_value", 32'(value[1]), 32'h3210);

    // Long hold of one digit, then a short glitch on slot 1
    s0 = strobes[0];
    drive({4'b1110, 7'b0000000}, 20);
    check("hold_no_strobe", 32'(strobes[0] - s0), 32'h0);
    drive({4'b1101, 7'b0001000}, 2);
    drive({4'b1011, 7'b0010000}, 4);
    drive({4'b0111, 7'b0000110}, 4);
    check("glitch_not_accepted", 32'(strobes[0] - s0), 32'h0);
    drive({4'b1101, 7'b1000110}, 4);
    check("glitch_frame_value", 32'(value[0]), 32'hE9C8);
    check("glitch_frame_count", 32'(strobes[0] - s0), 32'h1);

    // Blanked and multi-low anodes never fill slot 0
    s0 = strobes[0]; s1 = strobes[1];
    drive({4'b1111, 7'b0010010}, 10);
    drive({4'b1100, 7'b0010010}, 10);
    drive({4'b1101, 7'b1111001}, 4);
    drive({4'b1011, 7'b0100100}, 4);
    drive({4'b0111, 7'b0110000}, 4);
    check("bad_anode_s4", 32'(strobes[0] - s0), 32'h0);
    check("bad_anode_s1", 32'(strobes[1] - s1), 32'h0);
    drive({4'b1110, 7'b0011001}, 4);
    check("bad_anode_then_value", 32'(value[0]), 32'h3214);

    // Reset mid-frame discards three captured digits
    drive({4'b1110, 7'b0001110}, 4);
    drive({4'b1101, 7'b0001110}, 4);
    drive({4'b1011, 7'b0001110}, 4);
    reset = 1'b1;
    #1;
    check("async_reset_value", 32'(value[0]), 32'h0);
    check("async_reset_valid", 32'(value_valid[0]), 32'h0);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    s0 = strobes[0];
    drive({4'b0111, 7'b1111000}, 4);
    check("reset_no_stale", 32'(strobes[0] - s0), 32'h0);
    drive({4'b1110, 7'b0011001}, 4);
    drive({4'b1101, 7'b0010010}, 4);
    drive({4'b1011, 7'b0000010}, 4);
    check("reset_frame_7654", 32'(value[0]), 32'h7654);
    check("reset_frame_count", 32'(strobes[0] - s0), 32'h1);

    // Undecodable glyph in slot 2
    s0 = strobes[0];
    drive({4'b1110, 7'b0001000}, 4);
    drive({4'b1101, 7'b0000011}, 4);
    drive({4'b1011, 7'b1111111}, 4);
    drive({4'b0111, 7'b0100001}, 4);
`ifdef SSD_FRAME_DECODER_ERR_EN
    check("err_frame_value", 32'(value[0]), 32'hD0BA);
    check("err_frame_flag", 32'(frame_error[0]), 32'h1);
`else
    check("undecodable_no_frame", 32'(strobes[0] - s0), 32'h0);
    drive({4'b1011, 7'b0001110}, 4);
    check("undecodable_fixed_value", 32'(value[0]), 32'hDFBA);
    check("undecodable_error_low", 32'(frame_error[0]), 32'h0);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 80) an_r = ~(4'b0001 << $urandom_range(0, 3));
      else                            an_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 8) seg_r = FONT[$urandom_range(0, 15)];
      else                          seg_r = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        drive({an_r, seg_r}, 2);
        reset = 1'b0;
      end else begin
        drive({an_r, seg_r}, $urandom_range(1, 7));
      end
    end

    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
